led7x8_ctrl: RTL and testbench

//  Write controller and 2-way arbiter for the led7x8 display write port. Accepts
//  32-bit hex words (8 nibbles) from two requesters, arbitrates round-robin,
//  and sequences 8 timed writes (data/addr/wrn) per word. Drives init to blank the

---
 rtl/led7x8_pkg.sv | 29 ++
 rtl/led7x8_rr_arb2.sv | 31 +++
 rtl/led7x8_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_led7x8_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led7x8_pkg.sv
// rtl/led7x8_pkg.sv - shared types and constants for the led7x8 write controller
package led7x8_pkg;
  localparam int NUM_DIGITS   = 8;
  localparam int DIGIT_W      = 4;
  localparam int ADDR_W       = 3;
  localparam int WORD_W       = NUM_DIGITS * DIGIT_W;
  localparam int T_SETUP_DEF  = 3;
  localparam int T_PULSE_DEF  = 3;
  localparam int T_HOLD_DEF   = 3;
  localparam int INIT_CYC_DEF = 4;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_LOAD   = 3'd2,
    S_SETUP  = 3'd3,
    S_STROBE = 3'd4,
    S_HOLD   = 3'd5
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction
endpackage

// File: rtl/led7x8_rr_arb2.sv
// rtl/led7x8_rr_arb2.sv - two-request round-robin arbiter, priority flips on accept
module led7x8_rr_arb2 (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);
  // last_q=1 means requester 1 was served last, so requester 0 wins a tie
  logic last_q, last_d;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (accept && (|req)) last_d = grant[1];
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/led7x8_ctrl.sv
// rtl/led7x8_ctrl.sv - arbitrates two word requesters and sequences 8 timed led7x8 writes
// Optional skip of unchanged digits: define LED7X8_CHANGE_ONLY_EN.
module led7x8_ctrl
  import led7x8_pkg::*;
#(
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_PULSE  = T_PULSE_DEF,
  parameter int T_HOLD   = T_HOLD_DEF,
  parameter int INIT_CYC = INIT_CYC_DEF
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [WORD_W-1:0]  req0_word,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WORD_W-1:0]  req1_word,
  output logic               req1_ready,
  output logic               done,
  output logic               busy,
  output logic               gnt_id,
  output logic [DIGIT_W-1:0] disp_data,
  output logic [ADDR_W-1:0]  disp_addr,
  output logic               disp_wrn,
  output logic               disp_init
);
  localparam int CNT_W = $clog2(max4(T_SETUP, T_PULSE, T_HOLD, INIT_CYC)) + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_DIGITS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                gnt_q, gnt_d;
  logic [DIGIT_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          grant;
  logic                idle;
  logic                done_c;
  logic                skip;
  logic [DIGIT_W-1:0]  nibble;

  assign idle   = (state_q == S_IDLE);
  assign nibble = word_q[idx_q*DIGIT_W +: DIGIT_W];

  led7x8_rr_arb2 u_arb (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .accept (idle),
    .grant  (grant)
  );

`ifdef LED7X8_CHANGE_ONLY_EN
  logic [WORD_W-1:0]     shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shval_q, shval_d;

  assign skip = shval_q[idx_q] && (shadow_q[idx_q*DIGIT_W +: DIGIT_W] == nibble);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      shval_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      shval_q  <= shval_d;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    done_c  = 1'b0;
`ifdef LED7X8_CHANGE_ONLY_EN
    shadow_d = shadow_q;
    shval_d  = shval_q;
`endif
    case (state_q)
      S_INIT: begin
`ifdef LED7X8_CHANGE_ONLY_EN
        shval_d = '0;
`endif
        if (cnt_q == CNT_W'(INIT_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (|grant) begin
          word_d  = grant[1] ? req1_word : req0_word;
          gnt_d   = grant[1];
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Unchanged digits cost one LOAD cycle and no strobe
        if (skip) begin
          if (idx_q == LAST_IDX) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end else begin
          addr_d  = idx_q;
          data_d  = nibble;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(T_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == CNT_W'(T_PULSE - 1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(T_HOLD - 1)) begin
          cnt_d = '0;
`ifdef LED7X8_CHANGE_ONLY_EN
          shadow_d[idx_q*DIGIT_W +: DIGIT_W] = data_q;
          shval_d[idx_q]                     = 1'b1;
`endif
          if (idx_q == LAST_IDX) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      gnt_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  // wrn decodes straight from state so an async reset releases a strobe at once
  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];
  assign done       = done_c;
  assign busy       = ~idle;
  assign gnt_id     = gnt_q;
  assign disp_data  = data_q;
  assign disp_addr  = addr_q;
  assign disp_wrn   = (state_q != S_STROBE);
  assign disp_init  = (state_q == S_INIT);
endmodule

// File: tb/tb_led7x8_ctrl.sv
// tb/tb_led7x8_ctrl.sv - scoreboard bench for led7x8_ctrl (default and fast-timing instances)
module tb_led7x8_ctrl;
`ifdef LED7X8_CHANGE_ONLY_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rv [2][2];
  logic [31:0] rw [2][2];
  logic        rdy [2][2];
  logic        done_o [2];
  logic        busy_o [2];
  logic        gnt_o [2];
  logic        wrn_o [2];
  logic        init_o [2];
  logic [3:0]  data_o [2];
  logic [2:0]  addr_o [2];

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  logic [7:0]  exp_q [$];
  int          done_q [$];
  int          wr_cnt [2];
  logic [31:0] dm_dat [2];
  logic [7:0]  dm_val [2];
  logic [31:0] sh_dat [2];
  logic [7:0]  sh_val [2];

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  led7x8_ctrl dut (
    .clk_in(clk), .rst_n(rst_n),
    .req0_valid(rv[0][0]), .req0_word(rw[0][0]), .req0_ready(rdy[0][0]),
    .req1_valid(rv[0][1]), .req1_word(rw[0][1]), .req1_ready(rdy[0][1]),
    .done(done_o[0]), .busy(busy_o[0]), .gnt_id(gnt_o[0]),
    .disp_data(data_o[0]), .disp_addr(addr_o[0]), .disp_wrn(wrn_o[0]), .disp_init(init_o[0])
  );

  led7x8_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut_fast (
    .clk_in(clk), .rst_n(rst_n),
    .req0_valid(rv[1][0]), .req0_word(rw[1][0]), .req0_ready(rdy[1][0]),
    .req1_valid(rv[1][1]), .req1_word(rw[1][1]), .req1_ready(rdy[1][1]),
    .done(done_o[1]), .busy(busy_o[1]), .gnt_id(gnt_o[1]),
    .disp_data(data_o[1]), .disp_addr(addr_o[1]), .disp_wrn(wrn_o[1]), .disp_init(init_o[1])
  );

  // Driver model + scoreboard: each wrn falling edge is one display write
  for (genvar g = 0; g < 2; g++) begin : g_mon
    initial begin
      logic       prev;
      logic [7:0] got;
      logic [7:0] e;
      prev = 1'b1;
      forever begin
        @(negedge clk);
        if (init_o[g] === 1'b1) begin
          dm_val[g] = 8'h00;
          dm_dat[g] = 32'h0;
          sh_val[g] = 8'h00;
        end
        if (prev === 1'b1 && wrn_o[g] === 1'b0) begin
          wr_cnt[g]++;
          total_cnt++;
          got = {(g == 1), addr_o[g], data_o[g]};
          if (exp_q.size() == 0) begin
            $display("FAIL write_unexpected dut%0d got addr %0d data %h, required no write", g, addr_o[g], data_o[g]);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) $display("FAIL write_data dut%0d got %h, required %h", g, got, e);
            else pass_cnt++;
          end
          dm_dat[g][addr_o[g]*4 +: 4] = data_o[g];
          dm_val[g][addr_o[g]] = 1'b1;
        end
        if (done_o[g] === 1'b1) done_q.push_back(cyc);
        prev = wrn_o[g];
      end
    end
  end

  task automatic push_exp(input int g, input logic [31:0] w);
    logic [3:0] nib;
    for (int i = 0; i < 8; i++) begin
      nib = w[i*4 +: 4];
      if (!(CHG && sh_val[g][i] && sh_dat[g][i*4 +: 4] == nib)) begin
        exp_q.push_back({(g == 1), 3'(i), nib});
        sh_val[g][i] = 1'b1;
        sh_dat[g][i*4 +: 4] = nib;
      end
    end
  endtask

  task automatic send_word(input int g, input int r, input logic [31:0] w, output int rc);
    rc = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      rv[g][r] = 1'b1;
      rw[g][r] = w;
      #1;
      if (rdy[g][r] === 1'b1) begin
        rc = cyc;
        push_exp(g, w);
        break;
      end
    end
    @(negedge clk);
    rv[g][r] = 1'b0;
    #1;
  endtask

  task automatic wait_done(output int dc);
    dc = -1000;
    for (int t = 0; t < 400; t++) begin
      if (done_q.size() > 0) begin
        dc = done_q.pop_front();
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic release_count(output int n_init, output int n_wrn_low);
    n_init = 0;
    n_wrn_low = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (init_o[0] === 1'b1) n_init++;
      if (wrn_o[0] !== 1'b1) n_wrn_low++;
      @(negedge clk);
    end
    #1;
  endtask

  task automatic do_reset();
    int ni, nw;
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    release_count(ni, nw);
    done_q.delete();
  endtask

  task automatic test_reset();
    int ni, nw;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if (init_o[0] !== 1'b1) $display("FAIL rst_init got %b required 1", init_o[0]); else pass_cnt++;
    total_cnt++; if (wrn_o[0] !== 1'b1) $display("FAIL rst_wrn got %b required 1", wrn_o[0]); else pass_cnt++;
    total_cnt++; if (busy_o[0] !== 1'b1) $display("FAIL rst_busy got %b required 1", busy_o[0]); else pass_cnt++;
    total_cnt++; if (done_o[0] !== 1'b0) $display("FAIL rst_done got %b required 0", done_o[0]); else pass_cnt++;
    total_cnt++; if (gnt_o[0] !== 1'b0) $display("FAIL rst_gnt got %b required 0", gnt_o[0]); else pass_cnt++;
    total_cnt++; if (data_o[0] !== 4'h0) $display("FAIL rst_data got %h required 0", data_o[0]); else pass_cnt++;
    total_cnt++; if (addr_o[0] !== 3'd0) $display("FAIL rst_addr got %0d required 0", addr_o[0]); else pass_cnt++;
    total_cnt++; if (rdy[0][0] !== 1'b0 || rdy[0][1] !== 1'b0) $display("FAIL rst_ready got %b%b required 00", rdy[0][1], rdy[0][0]); else pass_cnt++;
    release_count(ni, nw);
    total_cnt++; if (ni !== 4) $display("FAIL init_cycles got %0d required 4", ni); else pass_cnt++;
    total_cnt++; if (nw !== 0) $display("FAIL init_wrn_low got %0d required 0", nw); else pass_cnt++;
    total_cnt++; if (busy_o[0] !== 1'b0) $display("FAIL idle_busy got %b required 0", busy_o[0]); else pass_cnt++;
  endtask

  task automatic test_basic();
    int rc, dc;
    send_word(0, 0, 32'h8765_4321, rc);
    total_cnt++; if (rc < 0) $display("FAIL basic_ready got timeout required pulse"); else pass_cnt++;
    total_cnt++; if (rdy[0][0] !== 1'b0) $display("FAIL basic_ready_pulse got %b required 0", rdy[0][0]); else pass_cnt++;
    total_cnt++; if (gnt_o[0] !== 1'b0 || busy_o[0] !== 1'b1) $display("FAIL basic_gnt got gnt %b busy %b required 0 1", gnt_o[0], busy_o[0]); else pass_cnt++;
    wait_done(dc);
    total_cnt++; if (dc - rc !== 80) $display("FAIL basic_latency got %0d required 80", dc - rc); else pass_cnt++;
    total_cnt++; if (dm_val[0] !== 8'hFF || dm_dat[0] !== 32'h8765_4321) $display("FAIL basic_display got %h mask %h required 87654321 mask ff", dm_dat[0], dm_val[0]); else pass_cnt++;
  endtask

  task automatic test_arb();
    int order[$];
    int rc[$];
    int c0, c1;
    logic [31:0] w0, w1;
    w0 = 32'h0123_4567;
    w1 = 32'h89AB_CDEF;
    do_reset();
    for (int round = 1; round <= 2; round++) begin
      order.delete();
      rc.delete();
      done_q.delete();
      c0 = round;
      c1 = round;
      for (int t = 0; t < 2000 && (c0 > 0 || c1 > 0); t++) begin
        @(negedge clk);
        rv[0][0] = (c0 > 0);
        rv[0][1] = (c1 > 0);
        rw[0][0] = w0;
        rw[0][1] = w1;
        #1;
        if (rdy[0][0] === 1'b1) begin order.push_back(0); rc.push_back(cyc); push_exp(0, w0); c0--; end
        if (rdy[0][1] === 1'b1) begin order.push_back(1); rc.push_back(cyc); push_exp(0, w1); c1--; end
      end
      @(negedge clk);
      rv[0][0] = 1'b0;
      rv[0][1] = 1'b0;
      for (int t = 0; t < 300 && done_q.size() < 2 * round; t++) begin
        @(negedge clk);
        #1;
      end
      total_cnt++;
      if (order.size() !== 2 * round || done_q.size() !== 2 * round)
        $display("FAIL arb_count round %0d got %0d readies %0d dones required %0d", round, order.size(), done_q.size(), 2 * round);
      else pass_cnt++;
      if (order.size() == 2 * round && done_q.size() == 2 * round) begin
        for (int k = 0; k < 2 * round; k++) begin
          total_cnt++; if (order[k] !== k % 2) $display("FAIL arb_order round %0d slot %0d got %0d required %0d", round, k, order[k], k % 2); else pass_cnt++;
          total_cnt++; if (done_q[k] - rc[k] !== 80) $display("FAIL arb_latency slot %0d got %0d required 80", k, done_q[k] - rc[k]); else pass_cnt++;
          if (k + 1 < 2 * round) begin
            total_cnt++; if (rc[k+1] !== done_q[k] + 1) $display("FAIL arb_next_ready slot %0d got cycle %0d required %0d", k + 1, rc[k+1], done_q[k] + 1); else pass_cnt++;
          end
        end
      end
      done_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int rc, base, ni, nw;
    do_reset();
    base = wr_cnt[0];
    send_word(0, 0, 32'h8765_4321, rc);
    for (int t = 0; t < 200 && wr_cnt[0] != base + 3; t++) begin
      @(negedge clk);
      #1;
    end
    total_cnt++; if (wrn_o[0] !== 1'b0 || wr_cnt[0] !== base + 3) $display("FAIL mid_strobe got wrn %b writes %0d required 0 %0d", wrn_o[0], wr_cnt[0] - base, 3); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (wrn_o[0] !== 1'b1) $display("FAIL mid_wrn got %b required 1", wrn_o[0]); else pass_cnt++;
    total_cnt++; if (init_o[0] !== 1'b1 || busy_o[0] !== 1'b1) $display("FAIL mid_init got init %b busy %b required 1 1", init_o[0], busy_o[0]); else pass_cnt++;
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    release_count(ni, nw);
    total_cnt++; if (ni !== 4) $display("FAIL mid_init_cycles got %0d required 4", ni); else pass_cnt++;
    repeat (100) @(negedge clk);
    #1;
    total_cnt++; if (wr_cnt[0] !== base + 3) $display("FAIL mid_no_writes got %0d required %0d", wr_cnt[0] - base, 3); else pass_cnt++;
    total_cnt++; if (dm_val[0] !== 8'h00) $display("FAIL mid_blank got mask %h required 00", dm_val[0]); else pass_cnt++;
    total_cnt++; if (done_q.size() !== 0) $display("FAIL mid_done got %0d required 0", done_q.size()); else pass_cnt++;
  endtask

  task automatic test_repeat();
    int rc, dc, base;
    do_reset();
    send_word(0, 1, 32'h0000_00AB, rc);
    wait_done(dc);
    total_cnt++; if (dc - rc !== 80) $display("FAIL rep_first_latency got %0d required 80", dc - rc); else pass_cnt++;
    base = wr_cnt[0];
    send_word(0, 1, 32'h0000_00AB, rc);
    wait_done(dc);
    total_cnt++; if (dc - rc !== (CHG ? 8 : 80)) $display("FAIL rep_same_latency got %0d required %0d", dc - rc, CHG ? 8 : 80); else pass_cnt++;
    total_cnt++; if (wr_cnt[0] - base !== (CHG ? 0 : 8)) $display("FAIL rep_same_writes got %0d required %0d", wr_cnt[0] - base, CHG ? 0 : 8); else pass_cnt++;
    base = wr_cnt[0];
    send_word(0, 1, 32'h0000_00AC, rc);
    wait_done(dc);
    total_cnt++; if (dc - rc !== (CHG ? 17 : 80)) $display("FAIL rep_diff_latency got %0d required %0d", dc - rc, CHG ? 17 : 80); else pass_cnt++;
    total_cnt++; if (wr_cnt[0] - base !== (CHG ? 1 : 8)) $display("FAIL rep_diff_writes got %0d required %0d", wr_cnt[0] - base, CHG ? 1 : 8); else pass_cnt++;
    total_cnt++; if (dm_dat[0] !== 32'h0000_00AC) $display("FAIL rep_display got %h required 000000ac", dm_dat[0]); else pass_cnt++;
  endtask

  task automatic test_fast();
    int rc, dc;
    logic [31:0] words [2];
    words[0] = 32'h1234_5678;
    words[1] = 32'h9ABC_DEF0;
    for (int n = 0; n < 2; n++) begin
      send_word(1, 1, words[n], rc);
      total_cnt++; if (gnt_o[1] !== 1'b1) $display("FAIL fast_gnt word %0d got %b required 1", n, gnt_o[1]); else pass_cnt++;
      wait_done(dc);
      total_cnt++; if (dc - rc !== 32) $display("FAIL fast_latency word %0d got %0d required 32", n, dc - rc); else pass_cnt++;
      total_cnt++; if (dm_dat[1] !== words[n] || dm_val[1] !== 8'hFF) $display("FAIL fast_display word %0d got %h required %h", n, dm_dat[1], words[n]); else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      wr_cnt[g] = 0;
      dm_val[g] = 8'h00;
      dm_dat[g] = 32'h0;
      sh_val[g] = 8'h00;
      sh_dat[g] = 32'h0;
      for (int r = 0; r < 2; r++) begin
        rv[g][r] = 1'b0;
        rw[g][r] = 32'h0;
      end
    end
    test_reset();
    test_basic();
    test_arb();
    test_reset_mid();
    test_repeat();
    test_fast();
    total_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
